// File: rtl/cb_search_pkg.sv
// Shared constants and state encoding for the LSP codebook search.
// Holds data width, codebook size, ROM address width and error saturation.
package cb_search_pkg;

  localparam int N       = 32;
  localparam int AW      = 4;
  localparam int CB_SIZE = 16;

  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/lsp_cb_search_ctrl_abs_diff.sv
// Saturated absolute difference of two signed Q15.16 words.
// The difference is formed in N+1 bits so it can never overflow.
module cb_abs_diff
  import cb_search_pkg::*;
(
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  logic [N:0] d;
  logic [N:0] m;

  always_comb begin
    d = {a[N-1], a} - {b[N-1], b};
    m = d[N] ? (~d + {{N{1'b0}}, 1'b1}) : d;
    y = (m > {1'b0, SAT_MAX}) ? SAT_MAX : m[N-1:0];
  end

endmodule

// File: rtl/lsp_cb_search_ctrl.sv
// Nearest-entry search over one scalar LSP codebook ROM.
// Define CB_SEARCH_EARLY_EXIT_EN to stop once the error starts rising.
module lsp_cb_search_ctrl
  import cb_search_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  target,
  output logic [AW-1:0] rom_addr,
  input  logic [N-1:0]  rom_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] best_idx,
  output logic [N-1:0]  best_err
);

  state_t        state;
  state_t        state_n;
  logic [N-1:0]  target_q;
  logic [N-1:0]  run_err;
  logic [AW-1:0] run_idx;
  logic [N-1:0]  err;
  logic          take;
  logic          fin;
  logic          last;

  cb_abs_diff u_diff (
    .a (target_q),
    .b (rom_data),
    .y (err)
  );

  assign last = (rom_addr == AW'(CB_SIZE - 1));
  assign busy = (state != ST_IDLE);

  always_comb begin
    state_n = state;
    take    = 1'b0;
    fin     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_n = ST_SEARCH;
      end
      ST_SEARCH: begin
        take = (err < run_err);
        fin  = last;
`ifdef CB_SEARCH_EARLY_EXIT_EN
        // ascending codebook: a rising error means the minimum is behind us
        if (rom_addr != '0 && err > run_err) fin = 1'b1;
`endif
        if (fin) state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rom_addr <= '0;
      target_q <= '0;
      run_err  <= SAT_MAX;
      run_idx  <= '0;
      done     <= 1'b0;
      best_idx <= '0;
      best_err <= '0;
    end else begin
      state <= state_n;
      done  <= (state == ST_DONE);
      if (state == ST_IDLE && start) begin
        target_q <= target;
        rom_addr <= '0;
        run_err  <= SAT_MAX;
        run_idx  <= '0;
      end
      if (take) begin
        run_err <= err;
        run_idx <= rom_addr;
      end
      if (state == ST_SEARCH && !fin) rom_addr <= rom_addr + AW'(1);
      if (state == ST_DONE) begin
        best_idx <= run_idx;
        best_err <= run_err;
      end
    end
  end

endmodule

// File: tb/tb_lsp_cb_search_ctrl.sv
// Directed bench for lsp_cb_search_ctrl with a 225..600 Hz, 25 Hz step ROM.
// Latencies follow CB_SEARCH_EARLY_EXIT_EN when that macro is defined.
module tb_lsp_cb_search_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] target = '0;
  logic [3:0]  rom_addr;
  logic [31:0] rom_data;
  logic        busy;
  logic        done;
  logic [3:0]  best_idx;
  logic [31:0] best_err;

  int checks = 0;
  int errors = 0;

`ifdef CB_SEARCH_EARLY_EXIT_EN
  localparam int L300  = 6;
  localparam int L0    = 3;
  localparam int L1000 = 17;
  localparam int LTIE  = 4;
  localparam logic [3:0] A300 = 4'd4;
`else
  localparam int L300  = 17;
  localparam int L0    = 17;
  localparam int L1000 = 17;
  localparam int LTIE  = 17;
  localparam logic [3:0] A300 = 4'd15;
`endif

  always #5 clk = ~clk;

  assign rom_data = (32'd225 + 32'd25 * 32'(rom_addr)) << 16;

  lsp_cb_search_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .target   (target),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done),
    .best_idx (best_idx),
    .best_err (best_err)
  );

  task automatic run_search(input logic [31:0] tg, output int lat,
                            output logic [3:0] idx, output logic [31:0] er,
                            output logic b1, output logic [3:0] a1);
    lat = -1;
    idx = '0;
    er  = '0;
    b1  = 1'b0;
    a1  = '0;
    @(negedge clk);
    target = tg;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        b1 = busy;
        a1 = rom_addr;
      end
      if (done) begin
        lat = i;
        idx = best_idx;
        er  = best_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %0b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %0b want 0", done);
    end
    checks++;
    if (rom_addr !== 4'd0) begin
      errors++; $display("FAIL reset_addr got %0d want 0", rom_addr);
    end
    checks++;
    if (best_idx !== 4'd0) begin
      errors++; $display("FAIL reset_idx got %0d want 0", best_idx);
    end
    checks++;
    if (best_err !== 32'd0) begin
      errors++; $display("FAIL reset_err got %h want 0", best_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [3:0] idx;
    logic [31:0] er;
    logic b1;
    logic [3:0] a1;
    run_search(32'h012C_0000, lat, idx, er, b1, a1);
    checks++;
    if (lat != L300) begin
      errors++; $display("FAIL basic_latency got %0d want %0d", lat, L300);
    end
    checks++;
    if (idx !== 4'd3) begin
      errors++; $display("FAIL basic_idx got %0d want 3", idx);
    end
    checks++;
    if (er !== 32'd0) begin
      errors++; $display("FAIL basic_err got %h want 0", er);
    end
    checks++;
    if (b1 !== 1'b1) begin
      errors++; $display("FAIL basic_busy got %0b want 1", b1);
    end
    checks++;
    if (a1 !== 4'd1) begin
      errors++; $display("FAIL basic_addr1 got %0d want 1", a1);
    end
    checks++;
    if (rom_addr !== A300) begin
      errors++; $display("FAIL basic_addr_hold got %0d want %0d", rom_addr, A300);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_pulse got done=%0b busy=%0b want 0 0", done, busy);
    end
  endtask

  task automatic test_extremes();
    int lat;
    logic [3:0] idx;
    logic [31:0] er;
    logic b1;
    logic [3:0] a1;
    run_search(32'h0000_0000, lat, idx, er, b1, a1);
    checks++;
    if (lat != L0) begin
      errors++; $display("FAIL low_latency got %0d want %0d", lat, L0);
    end
    checks++;
    if (idx !== 4'd0) begin
      errors++; $display("FAIL low_idx got %0d want 0", idx);
    end
    checks++;
    if (er !== 32'h00E1_0000) begin
      errors++; $display("FAIL low_err got %h want 00e10000", er);
    end
    run_search(32'h03E8_0000, lat, idx, er, b1, a1);
    checks++;
    if (lat != L1000) begin
      errors++; $display("FAIL high_latency got %0d want %0d", lat, L1000);
    end
    checks++;
    if (idx !== 4'd15) begin
      errors++; $display("FAIL high_idx got %0d want 15", idx);
    end
    checks++;
    if (er !== 32'h0190_0000) begin
      errors++; $display("FAIL high_err got %h want 01900000", er);
    end
    run_search(32'h8000_0000, lat, idx, er, b1, a1);
    checks++;
    if (idx !== 4'd0 || er !== 32'h7FFF_FFFF) begin
      errors++; $display("FAIL sat got idx=%0d err=%h want 0 7fffffff", idx, er);
    end
  endtask

  task automatic test_tie();
    int lat;
    logic [3:0] idx;
    logic [31:0] er;
    logic b1;
    logic [3:0] a1;
    run_search(32'h00ED_8000, lat, idx, er, b1, a1);
    checks++;
    if (lat != LTIE) begin
      errors++; $display("FAIL tie_latency got %0d want %0d", lat, LTIE);
    end
    checks++;
    if (idx !== 4'd0) begin
      errors++; $display("FAIL tie_idx got %0d want 0", idx);
    end
    checks++;
    if (er !== 32'h000C_8000) begin
      errors++; $display("FAIL tie_err got %h want 000c8000", er);
    end
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    int at = -1;
    logic [3:0] idx = '0;
    logic [31:0] er = '1;
    @(negedge clk);
    target = 32'h012C_0000;
    start  = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = (i == 5) || (i == L300);
      if (i == 3) target = 32'h03E8_0000;
      @(posedge clk);
      #1;
      if (done) begin
        cnt++;
        at  = i;
        idx = best_idx;
        er  = best_err;
      end
    end
    start = 1'b0;
    checks++;
    if (cnt != 1) begin
      errors++; $display("FAIL b2b_count got %0d want 1", cnt);
    end
    checks++;
    if (at != L300) begin
      errors++; $display("FAIL b2b_latency got %0d want %0d", at, L300);
    end
    checks++;
    if (idx !== 4'd3 || er !== 32'd0) begin
      errors++; $display("FAIL b2b_result got idx=%0d err=%h want 3 0", idx, er);
    end
  endtask

  task automatic test_abort();
    int cnt = 0;
    int lat;
    logic [3:0] idx;
    logic [31:0] er;
    logic b1;
    logic [3:0] a1;
    @(negedge clk);
    target = 32'h0190_0000;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rom_addr !== 4'd0) begin
      errors++;
      $display("FAIL abort_ctrl got busy=%0b done=%0b addr=%0d want 0 0 0",
               busy, done, rom_addr);
    end
    checks++;
    if (best_idx !== 4'd0 || best_err !== 32'd0) begin
      errors++; $display("FAIL abort_result got idx=%0d err=%h want 0 0", best_idx, best_err);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++; $display("FAIL abort_done got %0d pulses want 0", cnt);
    end
    run_search(32'h03E8_0000, lat, idx, er, b1, a1);
    checks++;
    if (lat != L1000 || idx !== 4'd15 || er !== 32'h0190_0000) begin
      errors++;
      $display("FAIL abort_restart got lat=%0d idx=%0d err=%h want %0d 15 01900000",
               lat, idx, er, L1000);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_tie();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
